// File: rtl/neuron_core_wb_initiator.sv
// neuron_core_wb_initiator: buffers commands in a small FIFO and issues one
// Wishbone classic single cycle per in-range command, one response per command.
// Optional feature macro: WB_TIMEOUT_EN (abort a BUS cycle that never acks).
module neuron_core_wb_initiator #(
   parameter int          FIFO_DEPTH     = 4,
   parameter int          TIMEOUT_CYCLES = 255,
   parameter logic [31:0] ADDR_LO        = 32'h3000_0000,
   parameter logic [31:0] ADDR_HI        = 32'h3000_FFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic        cmd_we_i,
   input  logic [3:0]  cmd_sel_i,
   input  logic [31:0] cmd_adr_i,
   input  logic [31:0] cmd_dat_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_dat_o,
   output logic        rsp_err_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic        wbm_ack_i,
   input  logic [31:0] wbm_dat_i,
   output logic        busy_o
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of 2 and at least 2");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_tmo
      $error("TIMEOUT_CYCLES must be in 1..255");
   end

   typedef struct packed {
      logic        we;
      logic [3:0]  sel;
      logic [31:0] adr;
      logic [31:0] dat;
   } cmd_t;

   typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

   cmd_t          fifo_q [FIFO_DEPTH];
   cmd_t          fifo_d [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   state_t        state_q, state_d;
   logic          cyc_q, cyc_d, we_q, we_d, rsp_err_q, rsp_err_d;
   logic [3:0]    sel_q, sel_d;
   logic [31:0]   adr_q, adr_d, dat_q, dat_d, rsp_dat_q, rsp_dat_d;
   logic          full, push, pop;
   cmd_t          head;
`ifdef WB_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0]    tmo_q, tmo_d;
`endif

   // ready depends only on the FIFO count, never on the FSM
   assign full        = (cnt_q == DEPTH_C);
   assign cmd_ready_o = !full;
   assign push        = cmd_valid_i && !full;
   assign pop         = (state_q == S_IDLE) && (cnt_q != '0);
   assign head        = fifo_q[rd_ptr_q];

   // FIFO next state: storage write, pointer and count update
   always_comb begin
      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) begin
         fifo_d[wr_ptr_q] = {cmd_we_i, cmd_sel_i, cmd_adr_i, cmd_dat_i};
         wr_ptr_d         = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // FSM next state plus bus request and response registers
   always_comb begin
      state_d   = state_q;
      cyc_d     = cyc_q;
      we_d      = we_q;
      sel_d     = sel_q;
      adr_d     = adr_q;
      dat_d     = dat_q;
      rsp_dat_d = rsp_dat_q;
      rsp_err_d = rsp_err_q;
`ifdef WB_TIMEOUT_EN
      tmo_d     = tmo_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (pop) begin
               if (head.adr >= ADDR_LO && head.adr <= ADDR_HI) begin
                  cyc_d   = 1'b1;
                  we_d    = head.we;
                  sel_d   = head.sel;
                  adr_d   = head.adr;
                  dat_d   = head.dat;
                  state_d = S_BUS;
`ifdef WB_TIMEOUT_EN
                  tmo_d   = '0;
`endif
               end else begin
                  // out of range: answer immediately, bus stays untouched
                  rsp_err_d = 1'b1;
                  rsp_dat_d = '0;
                  state_d   = S_RESP;
               end
            end
         end
         S_BUS: begin
            if (wbm_ack_i) begin
               cyc_d     = 1'b0;
               rsp_dat_d = we_q ? '0 : wbm_dat_i;
               rsp_err_d = 1'b0;
               state_d   = S_RESP;
            end
`ifdef WB_TIMEOUT_EN
            else if (tmo_q == TMO_LAST) begin
               cyc_d     = 1'b0;
               rsp_dat_d = '0;
               rsp_err_d = 1'b1;
               state_d   = S_RESP;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
`endif
         end
         S_RESP: begin
            if (rsp_ready_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FIFO storage; contents are don't-care while the count is zero
   always_ff @(posedge clk) begin
      fifo_q <= fifo_d;
   end

   // control state with synchronous reset; reset drops cyc/stb and flushes the FIFO
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         state_q   <= S_IDLE;
         cyc_q     <= 1'b0;
         we_q      <= 1'b0;
         sel_q     <= '0;
         adr_q     <= '0;
         dat_q     <= '0;
         rsp_dat_q <= '0;
         rsp_err_q <= 1'b0;
`ifdef WB_TIMEOUT_EN
         tmo_q     <= '0;
`endif
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
         state_q   <= state_d;
         cyc_q     <= cyc_d;
         we_q      <= we_d;
         sel_q     <= sel_d;
         adr_q     <= adr_d;
         dat_q     <= dat_d;
         rsp_dat_q <= rsp_dat_d;
         rsp_err_q <= rsp_err_d;
`ifdef WB_TIMEOUT_EN
         tmo_q     <= tmo_d;
`endif
      end
   end

   assign wbm_cyc_o   = cyc_q;
   assign wbm_stb_o   = cyc_q;
   assign wbm_we_o    = we_q;
   assign wbm_sel_o   = sel_q;
   assign wbm_adr_o   = adr_q;
   assign wbm_dat_o   = dat_q;
   assign rsp_valid_o = (state_q == S_RESP);
   assign rsp_dat_o   = rsp_dat_q;
   assign rsp_err_o   = rsp_err_q;
   assign busy_o      = (cnt_q != '0) || (state_q != S_IDLE);

endmodule

// File: tb/tb_neuron_core_wb_initiator.sv
// Bench for neuron_core_wb_initiator: directed steps then random commands,
// checked against a transaction-level model (expected response/bus queues).
module tb_neuron_core_wb_initiator;
   localparam logic [31:0] LO = 32'h3000_0000;
   localparam logic [31:0] HI = 32'h3000_FFFF;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
   logic [3:0]  cmd_sel_i;
   logic [31:0] cmd_adr_i, cmd_dat_i;
   logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
   logic [31:0] rsp_dat_o;
   logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
   logic        busy_o;

   always #5 clk = ~clk;

   neuron_core_wb_initiator #(
      .FIFO_DEPTH(4), .TIMEOUT_CYCLES(8), .ADDR_LO(LO), .ADDR_HI(HI)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
      .cmd_sel_i(cmd_sel_i), .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
      .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
      .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
      .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i), .busy_o(busy_o)
   );

   typedef struct packed { logic err; logic [31:0] dat; } rsp_t;
   typedef struct packed { logic we; logic [3:0] sel; logic [31:0] adr; logic [31:0] dat; } bus_t;

   rsp_t rsp_q[$], exp_rsp_q[$];
   bus_t bus_q[$], exp_bus_q[$];
   int   len_q[$];
   logic [31:0] smem [logic [29:0]];
   logic [31:0] mmem [logic [29:0]];

   int   pass_cnt = 0, fail_cnt = 0, total_cnt = 0, unstable = 0;
   int   slave_wait = 0;
   bit   slave_noack = 0, slave_rand = 0, rand_rdy = 0;
   logic rdy_dir = 1'b0, rdy_rnd = 1'b0;

   assign rsp_ready_i = rand_rdy ? rdy_rnd : rdy_dir;

   function automatic logic [31:0] dflt(input logic [31:0] a);
      return {a[15:2], 2'b00, ~a[15:2], 2'b11};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Wishbone slave: acks after a programmable number of wait cycles, backed by smem
   initial begin : slave
      int wcnt, tgt;
      bit active;
      logic [29:0] k;
      logic [31:0] w;
      wbm_ack_i = 1'b0; wbm_dat_i = '0; wcnt = 0; tgt = 0; active = 0;
      forever begin
         @(posedge clk); #1;
         wbm_ack_i = 1'b0; wbm_dat_i = '0;
         if (wbm_cyc_o === 1'b1 && wbm_stb_o === 1'b1) begin
            if (!active) begin
               active = 1; wcnt = 0;
               tgt = slave_rand ? int'($urandom_range(0, 3)) : slave_wait;
            end
            if (!slave_noack && wcnt == tgt) begin
               wbm_ack_i = 1'b1;
               k = wbm_adr_o[31:2];
               w = smem.exists(k) ? smem[k] : dflt(wbm_adr_o);
               if (wbm_we_o) begin
                  for (int b = 0; b < 4; b++)
                     if (wbm_sel_o[b]) w[8*b +: 8] = wbm_dat_o[8*b +: 8];
                  smem[k] = w;
               end else begin
                  wbm_dat_i = w;
               end
            end
            wcnt++;
         end else begin
            active = 0;
         end
      end
   end

   // bus monitor: completed transfers, cyc length, request stability
   initial begin : bus_mon
      int cur;
      bus_t prev, now;
      cur = 0; prev = '0;
      forever begin
         @(negedge clk);
         now = '{we: wbm_we_o, sel: wbm_sel_o, adr: wbm_adr_o, dat: (wbm_we_o ? wbm_dat_o : 32'h0)};
         if (rst !== 1'b0) cur = 0;
         else if (wbm_cyc_o === 1'b1) begin
            if (cur > 0 && now !== prev) unstable++;
            if (wbm_stb_o !== 1'b1) unstable++;
            if (wbm_ack_i === 1'b1) bus_q.push_back(now);
            prev = now; cur++;
         end else if (cur > 0) begin
            len_q.push_back(cur); cur = 0;
         end
      end
   end

   // response monitor: handshake completes at the following edge
   initial forever begin
      @(negedge clk);
      if (rst === 1'b0 && rsp_valid_o === 1'b1 && rsp_ready_i === 1'b1)
         rsp_q.push_back('{err: rsp_err_o, dat: rsp_dat_o});
   end

   initial forever begin
      @(posedge clk); #1;
      rdy_rnd = 1'($urandom_range(0, 1));
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic push(input logic we, input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
      int guard;
      guard = 0;
      @(negedge clk);
      cmd_valid_i = 1'b1; cmd_we_i = we; cmd_sel_i = sel; cmd_adr_i = adr; cmd_dat_i = dat;
      while (cmd_ready_o !== 1'b1 && guard < 2000) begin
         @(negedge clk); guard++;
      end
      @(posedge clk); #1;
      cmd_valid_i = 1'b0;
   endtask

   // reference model: in-range commands make one bus transfer, others an error response
   task automatic send(input logic we, input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
      logic [29:0] k;
      logic [31:0] w;
      k = adr[31:2];
      w = mmem.exists(k) ? mmem[k] : dflt(adr);
      if (adr >= LO && adr <= HI) begin
         exp_bus_q.push_back('{we: we, sel: sel, adr: adr, dat: (we ? dat : 32'h0)});
         if (we) begin
            for (int b = 0; b < 4; b++)
               if (sel[b]) w[8*b +: 8] = dat[8*b +: 8];
            mmem[k] = w;
            exp_rsp_q.push_back('{err: 1'b0, dat: 32'h0});
         end else begin
            exp_rsp_q.push_back('{err: 1'b0, dat: w});
         end
      end else begin
         exp_rsp_q.push_back('{err: 1'b1, dat: 32'h0});
      end
      push(we, sel, adr, dat);
   endtask

   task automatic preload(input logic [31:0] adr, input logic [31:0] v);
      smem[adr[31:2]] = v;
      mmem[adr[31:2]] = v;
   endtask

   task automatic set_rdy(input logic v);
      @(posedge clk); #1;
      rdy_dir = v;
   endtask

   task automatic wait_rsp(input int n);
      int g;
      g = 0;
      while (rsp_q.size() < n && g < 3000) begin
         @(negedge clk); g++;
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic compare_all(input string tag);
      rsp_t a, e;
      bus_t ba, be;
      check({tag, "_nrsp"}, 32'(rsp_q.size()), 32'(exp_rsp_q.size()));
      while (rsp_q.size() > 0 && exp_rsp_q.size() > 0) begin
         a = rsp_q.pop_front(); e = exp_rsp_q.pop_front();
         check({tag, "_err"}, 32'(a.err), 32'(e.err));
         check({tag, "_dat"}, a.dat, e.dat);
      end
      check({tag, "_nbus"}, 32'(bus_q.size()), 32'(exp_bus_q.size()));
      while (bus_q.size() > 0 && exp_bus_q.size() > 0) begin
         ba = bus_q.pop_front(); be = exp_bus_q.pop_front();
         check({tag, "_bus_adr"}, ba.adr, be.adr);
         check({tag, "_bus_we"}, 32'(ba.we), 32'(be.we));
         check({tag, "_bus_sel"}, 32'(ba.sel), 32'(be.sel));
         check({tag, "_bus_dat"}, ba.dat, be.dat);
      end
      rsp_q.delete(); exp_rsp_q.delete(); bus_q.delete(); exp_bus_q.delete();
   endtask

   function automatic int first_len();
      return (len_q.size() != 0) ? len_q[0] : -1;
   endfunction

   initial begin
      logic [31:0] a;
      rst = 1'b1; cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_sel_i = '0; cmd_adr_i = '0; cmd_dat_i = '0;
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      check("rst_cyc", 32'(wbm_cyc_o), 32'd0);
      check("rst_stb", 32'(wbm_stb_o), 32'd0);
      check("rst_we", 32'(wbm_we_o), 32'd0);
      check("rst_sel", 32'(wbm_sel_o), 32'd0);
      check("rst_adr", wbm_adr_o, 32'd0);
      check("rst_dat", wbm_dat_o, 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
      check("rst_rsp_dat", rsp_dat_o, 32'd0);
      check("rst_rsp_err", 32'(rsp_err_o), 32'd0);
      check("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
      check("rst_busy", 32'(busy_o), 32'd0);

      // single write, slave acks right away
      set_rdy(1'b1); slave_wait = 0; len_q.delete();
      send(1'b1, 4'hF, 32'h3000_4010, 32'h0000_00A5);
      @(negedge clk);
      check("t1_cyc_after_accept", 32'(wbm_cyc_o), 32'd0);
      check("t1_busy", 32'(busy_o), 32'd1);
      @(negedge clk);
      check("t1_cyc_after_pop", 32'(wbm_cyc_o), 32'd1);
      check("t1_stb_after_pop", 32'(wbm_stb_o), 32'd1);
      check("t1_we", 32'(wbm_we_o), 32'd1);
      check("t1_adr", wbm_adr_o, 32'h3000_4010);
      check("t1_dat", wbm_dat_o, 32'h0000_00A5);
      wait_rsp(1);
      compare_all("t1");
      check("t1_cyc_len", 32'(first_len()), 32'd1);

      // read with three wait states
      preload(32'h3000_8000, 32'h8000_0001);
      slave_wait = 3; len_q.delete();
      send(1'b0, 4'hF, 32'h3000_8000, 32'h0);
      wait_rsp(1);
      compare_all("t2");
      check("t2_cyc_len", 32'(first_len()), 32'd4);

      // out-of-range read: error response one cycle after pop, no bus cycle
      set_rdy(1'b0); len_q.delete();
      send(1'b0, 4'hF, 32'h2000_0000, 32'h0);
      @(negedge clk);
      check("t3_rsp_before_pop", 32'(rsp_valid_o), 32'd0);
      @(negedge clk);
      check("t3_rsp_valid", 32'(rsp_valid_o), 32'd1);
      check("t3_rsp_err", 32'(rsp_err_o), 32'd1);
      check("t3_rsp_dat", rsp_dat_o, 32'd0);
      check("t3_cyc", 32'(wbm_cyc_o), 32'd0);
      set_rdy(1'b1);
      wait_rsp(1);
      compare_all("t3");
      check("t3_no_cyc", 32'(len_q.size()), 32'd0);

      // fill the FIFO while the first response is held, boundaries included
      set_rdy(1'b0); slave_wait = 0; len_q.delete();
      send(1'b1, 4'h3, LO, 32'h1234_5678);
      send(1'b0, 4'hF, HI, 32'h0);
      send(1'b0, 4'hF, LO - 32'd1, 32'h0);
      send(1'b1, 4'hF, HI + 32'd1, 32'hFFFF_FFFF);
      send(1'b0, 4'hF, LO, 32'h0);
      @(negedge clk);
      check("t4_ready_full", 32'(cmd_ready_o), 32'd0);
      check("t4_busy_full", 32'(busy_o), 32'd1);
      check("t4_no_rsp_yet", 32'(rsp_q.size()), 32'd0);
      set_rdy(1'b1);
      send(1'b0, 4'hF, 32'h3000_4010, 32'h0);
      wait_rsp(6);
      compare_all("t4");

`ifdef WB_TIMEOUT_EN
      // slave never acks: abort after 8 BUS cycles
      slave_noack = 1; len_q.delete();
      exp_rsp_q.push_back('{err: 1'b1, dat: 32'h0});
      push(1'b0, 4'hF, 32'h3000_0100, 32'h0);
      wait_rsp(1);
      compare_all("tmo");
      check("tmo_cyc_len", 32'(first_len()), 32'd8);
      // ack on the 8th BUS cycle wins
      slave_noack = 0; slave_wait = 7; len_q.delete();
      preload(32'h3000_0100, 32'hCAFE_0100);
      send(1'b0, 4'hF, 32'h3000_0100, 32'h0);
      wait_rsp(1);
      compare_all("tmo_ack");
      check("tmo_ack_cyc_len", 32'(first_len()), 32'd8);
`endif

      // random commands with random slave latency and response back-pressure
      @(posedge clk); #1;
      slave_rand = 1; rand_rdy = 1;
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 9))
            0:       a = LO;
            1:       a = HI;
            2:       a = LO - 32'd1;
            3:       a = HI + 32'd1;
            4:       a = $urandom;
            default: a = {24'h300000, 2'b00, 4'($urandom_range(0, 15)), 2'b00};
         endcase
         send(1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), a, $urandom);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      wait_rsp(40);
      @(posedge clk); #1;
      rand_rdy = 0; slave_rand = 0; rdy_dir = 1'b1;
      compare_all("rnd");
      check("req_stable", 32'(unstable), 32'd0);

      // reset while in BUS with two commands queued
      slave_noack = 1; len_q.delete();
      push(1'b0, 4'hF, 32'h3000_0200, 32'h0);
      push(1'b0, 4'hF, 32'h3000_0204, 32'h0);
      push(1'b1, 4'hF, 32'h3000_0208, 32'h0);
      @(negedge clk);
      check("rr_cyc_before", 32'(wbm_cyc_o), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rr_cyc", 32'(wbm_cyc_o), 32'd0);
      check("rr_stb", 32'(wbm_stb_o), 32'd0);
      check("rr_busy", 32'(busy_o), 32'd0);
      check("rr_rsp_valid", 32'(rsp_valid_o), 32'd0);
      check("rr_cmd_ready", 32'(cmd_ready_o), 32'd1);
      slave_noack = 0;
      repeat (20) @(negedge clk);
      check("rr_no_rsp", 32'(rsp_q.size()), 32'd0);
      check("rr_no_bus", 32'(bus_q.size()), 32'd0);
      check("rr_idle", 32'(busy_o), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
